// File: rtl/data_write_buffer.sv
// rtl/data_write_buffer.sv - write-through store buffer between data cache and backing memory
//
// Purpose:
//   Circular FIFO of store entries (address/data) that a drain FSM retires to
//   memory one at a time over a req/ack handshake. Loads snoop the buffer and
//   get the youngest matching word so they never see stale memory data.
//
// Configuration:
//   WBUF_COALESCE_EN - when defined, a store whose word address matches a
//   buffered entry (other than the head currently being written to memory)
//   overwrites that entry instead of allocating a new one.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data store push from the cache (held by upstream while stall=1)
//   rd_en/rd_addr         load snoop
//   fwd_hit/fwd_data      combinational snoop result (youngest match, 0 on miss)
//   stall                 store presented but not accepted this cycle
//   mem_req/mem_addr/mem_wdata/mem_ack  registered write handshake to memory
//   empty/count           registered occupancy
module data_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic                     stall,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, REQ} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [PW-1:0]       head_q, tail_q;
  logic [CW-1:0]       count_q, count_d;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic                merge_hit;
  logic [PW-1:0]       merge_idx;
  logic                push_alloc;
  logic                pop;
  logic                fwd_hit_c;
  logic [PW-1:0]       fwd_idx;
  logic [DATA_W-1:0]   head_load_data;

  // Byte offset bits never take part in word compares.
  logic unused_low_bits;
  assign unused_low_bits = ^rd_addr[1:0];

  // Snoop: walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit_c = 1'b0;
    fwd_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_en && valid_q[head_q + PW'(k)] &&
          addr_q[head_q + PW'(k)][ADDR_W-1:2] == rd_addr[ADDR_W-1:2]) begin
        fwd_hit_c = 1'b1;
        fwd_idx   = head_q + PW'(k);
      end
    end
  end

  assign fwd_hit  = fwd_hit_c;
  assign fwd_data = fwd_hit_c ? data_q[fwd_idx] : '0;

`ifdef WBUF_COALESCE_EN
  // Merge target: youngest valid match, excluding the head while its data is
  // already on the memory bus.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (wr_en && valid_q[head_q + PW'(k)] &&
          addr_q[head_q + PW'(k)][ADDR_W-1:2] == wr_addr[ADDR_W-1:2] &&
          !(state_q == REQ && (head_q + PW'(k)) == head_q)) begin
        merge_hit = 1'b1;
        merge_idx = head_q + PW'(k);
      end
    end
  end
`else
  assign merge_hit = 1'b0;
  assign merge_idx = '0;
`endif

  // count_q is the pre-edge value, so a pop in the same cycle never frees room.
  assign push_alloc = wr_en && !merge_hit && (count_q != FULL);
  assign stall      = wr_en && !merge_hit && (count_q == FULL);
  assign pop        = (state_q == REQ) && mem_ack;

  // A merge into the head on the same edge IDLE loads it must carry the new data.
  assign head_load_data = (merge_hit && merge_idx == head_q) ? wr_data : data_q[head_q];

  always_comb begin
    count_d = count_q;
    case ({push_alloc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push_alloc) begin
        addr_q[tail_q]  <= wr_addr;
        data_q[tail_q]  <= wr_data;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (merge_hit) begin
        data_q[merge_idx] <= wr_data;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      count_q <= count_d;

      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= addr_q[head_q];
            mem_wdata_q <= head_load_data;
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: tb/tb_data_write_buffer.sv
// tb/tb_data_write_buffer.sv - directed self-checking bench for data_write_buffer
module tb_data_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .empty(empty), .count(count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input logic [31:0] dbase, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_addr = base + 32'(4 * i);
      wr_data = dbase + 32'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; mem_ack = 1'b0;
    tick(); tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem got req=%b addr=%h data=%h want 0/0/0", mem_req, mem_addr, mem_wdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    mem_ack = 1'b1;
    wr_en = 1'b1; wr_addr = 32'h100; wr_data = 32'hAAAA0001;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL single_stall got %b want 0", stall); end
    tick();
    wr_en = 1'b0;
    checks++; if (count !== 3'd1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL single_push got count=%0d req=%b want 1/0", count, mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hAAAA0001) begin
      errors++; $display("FAIL single_req got req=%b addr=%h data=%h want 1/100/aaaa0001", mem_req, mem_addr, mem_wdata); end
    tick();
    checks++; if (mem_req !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL single_drain got req=%b empty=%b want 0/1", mem_req, empty); end
    mem_ack = 1'b0;
  endtask

  task automatic test_full_stall;
    logic [31:0] exp_addr [4];
    int n;
    exp_addr[0] = 32'h14; exp_addr[1] = 32'h18; exp_addr[2] = 32'h1C; exp_addr[3] = 32'h20;
    mem_ack = 1'b0;
    fill(32'h10, 32'hD000_0000, 4);
    checks++; if (count !== 3'd4 || mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL full_fill got count=%0d req=%b addr=%h want 4/1/10", count, mem_req, mem_addr); end
    wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'hD000_0020;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b want 1", stall); end
    tick();
    checks++; if (count !== 3'd4 || stall !== 1'b1) begin
      errors++; $display("FAIL full_hold got count=%0d stall=%b want 4/1", count, stall); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    checks++; if (count !== 3'd3 || stall !== 1'b0) begin
      errors++; $display("FAIL full_afterpop got count=%0d stall=%b want 3/0", count, stall); end
    tick();
    wr_en = 1'b0;
    checks++; if (count !== 3'd4 || mem_req !== 1'b1 || mem_addr !== 32'h14) begin
      errors++; $display("FAIL full_accept got count=%0d req=%b addr=%h want 4/1/14", count, mem_req, mem_addr); end
    mem_ack = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (mem_req) begin
        checks++; if (mem_addr !== exp_addr[n]) begin
          errors++; $display("FAIL drain_order[%0d] got %h want %h", n, mem_addr, exp_addr[n]); end
        n++;
      end
      tick();
    end
    checks++; if (n !== 4 || empty !== 1'b1) begin
      errors++; $display("FAIL drain_done got n=%0d empty=%b want 4/1", n, empty); end
    mem_ack = 1'b0;
  endtask

  task automatic test_forward;
    mem_ack = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'h11111111;
    tick();
    wr_data = 32'h22222222;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 32'h42;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22222222) begin
      errors++; $display("FAIL fwd_young got hit=%b data=%h want 1/22222222", fwd_hit, fwd_data); end
`ifdef WBUF_COALESCE_EN
    checks++; if (count !== 3'd1 || mem_wdata !== 32'h22222222) begin
      errors++; $display("FAIL fwd_count got count=%0d wdata=%h want 1/22222222", count, mem_wdata); end
`else
    checks++; if (count !== 3'd2 || mem_wdata !== 32'h11111111) begin
      errors++; $display("FAIL fwd_count got count=%0d wdata=%h want 2/11111111", count, mem_wdata); end
`endif
    rd_addr = 32'h300;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      errors++; $display("FAIL fwd_miss got hit=%b data=%h want 0/0", fwd_hit, fwd_data); end
    rd_en = 1'b0;
    mem_ack = 1'b1;
    for (int c = 0; c < 20 && !(empty && !mem_req); c++) tick();
    checks++; if (empty !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL fwd_drain got empty=%b req=%b want 1/0", empty, mem_req); end
    mem_ack = 1'b0;
  endtask

  task automatic test_full_ack;
    mem_ack = 1'b0;
    fill(32'h80, 32'hB000_0000, 4);
    wr_en = 1'b1; wr_addr = 32'h90; wr_data = 32'hB000_0090;
    mem_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fullack_stall got %b want 1", stall); end
    tick();
    wr_en = 1'b0; mem_ack = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullack_count got %0d want 3", count); end
  endtask

  task automatic test_reset_mid;
    int seen;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h84 || count !== 3'd3) begin
      errors++; $display("FAIL midrst_pre got req=%b addr=%h count=%0d want 1/84/3", mem_req, mem_addr, count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL midrst_async got req=%b count=%0d empty=%b want 0/0/1", mem_req, count, empty); end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (mem_req) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_noreq got %0d req cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_stall();
    test_forward();
    test_full_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
